// File: rtl/pry2oht_pkg.sv
// Shared types and helpers for the rightmost-priority round-robin arbiter.
package pry2oht_pkg;

    localparam int MAX_WIDTH = 1024;

    typedef enum logic [1:0] {EMPTY, GRANT, LOCK} state_e;

    // One-hot in, mask of the bits strictly above the set bit out; zero in gives zero.
    function automatic logic [MAX_WIDTH-1:0] mask_above(input logic [MAX_WIDTH-1:0] oht);
        return ~(oht | (oht - MAX_WIDTH'(1)));
    endfunction

endpackage

// File: rtl/pry2oht_bck_tree.sv
// Rightmost-priority to one-hot converter as a radix-SPLIT tree.
module pry2oht_bck_tree #(
    parameter int WIDTH          = 32,
    parameter int SPLIT          = 2,
    parameter int IMPLEMENTATION = 0
) (
    input  logic             ena,
    input  logic [WIDTH-1:0] pry,
    output logic [WIDTH-1:0] oht
);

    if (WIDTH <= SPLIT) begin : g_leaf
        if (IMPLEMENTATION == 0) begin : g_arith
            assign oht = ena ? (pry & (~pry + WIDTH'(1))) : '0;
        end else begin : g_scan
            logic found;
            always_comb begin
                oht   = '0;
                found = 1'b0;
                for (int i = 0; i < WIDTH; i++) begin
                    if (ena && pry[i] && !found) begin
                        oht[i] = 1'b1;
                        found  = 1'b1;
                    end
                end
            end
        end
    end else begin : g_node
        localparam int SUB = WIDTH / SPLIT;
        logic [SPLIT-1:0] any;
        logic [SPLIT-1:0] sel;

        for (genvar g = 0; g < SPLIT; g++) begin : g_any
            assign any[g] = |pry[g*SUB +: SUB];
        end

        // Pick the rightmost non-empty group, then enable only that subtree.
        pry2oht_bck_tree #(.WIDTH(SPLIT), .SPLIT(SPLIT), .IMPLEMENTATION(IMPLEMENTATION)) u_grp (
            .ena (ena),
            .pry (any),
            .oht (sel)
        );

        for (genvar g = 0; g < SPLIT; g++) begin : g_sub
            pry2oht_bck_tree #(.WIDTH(SUB), .SPLIT(SPLIT), .IMPLEMENTATION(IMPLEMENTATION)) u_sub (
                .ena (sel[g]),
                .pry (pry[g*SUB +: SUB]),
                .oht (oht[g*SUB +: SUB])
            );
        end
    end

endmodule

// File: rtl/pry2oht_rr_arb.sv
// Registered round-robin arbiter with valid/ready grant and multi-beat lock.
module pry2oht_rr_arb
    import pry2oht_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter int SPLIT          = 2,
    parameter int IMPLEMENTATION = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] req,
    input  logic             ena,
    input  logic             lck,
    output logic [WIDTH-1:0] oht,
    output logic             vld,
    input  logic             rdy
);

    state_e           state, state_d;
    logic [WIDTH-1:0] msk, msk_d, oht_d;
    logic [WIDTH-1:0] above, eff_msk, req_m, cand_m, cand_u, cand;
    logic             xfer, hold_lock;

    assign xfer  = vld & rdy;
    assign above = WIDTH'(mask_above(MAX_WIDTH'(oht)));

    // On a transfer the outgoing grant's mask is used immediately so the
    // reload in the same cycle already rotates past it.
    assign eff_msk = xfer ? above : msk;
    assign req_m   = req & eff_msk;

    pry2oht_bck_tree #(.WIDTH(WIDTH), .SPLIT(SPLIT), .IMPLEMENTATION(IMPLEMENTATION)) u_masked (
        .ena (1'b1),
        .pry (req_m),
        .oht (cand_m)
    );

    pry2oht_bck_tree #(.WIDTH(WIDTH), .SPLIT(SPLIT), .IMPLEMENTATION(IMPLEMENTATION)) u_unmasked (
        .ena (1'b1),
        .pry (req),
        .oht (cand_u)
    );

    assign cand      = (|req_m) ? cand_m : cand_u;
    assign hold_lock = xfer & lck & (|(req & oht));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= EMPTY;
            oht   <= '0;
            msk   <= '1;
        end else begin
            state <= state_d;
            oht   <= oht_d;
            msk   <= msk_d;
        end
    end

    always_comb begin
        state_d = state;
        oht_d   = oht;
        msk_d   = msk;
        if (hold_lock) begin
            // Same owner keeps the grant; mask stays put until the lock ends.
            state_d = LOCK;
        end else if (xfer || (!vld && ena)) begin
            if (xfer) msk_d = above;
            if (ena && (|cand)) begin
                oht_d   = cand;
                state_d = GRANT;
            end else begin
                oht_d   = '0;
                state_d = EMPTY;
            end
        end
    end

    always_comb begin
        vld = (state != EMPTY);
    end

endmodule

// File: tb/tb_pry2oht_rr_arb.sv
// Directed bench for pry2oht_rr_arb at WIDTH=8, SPLIT=2.
module tb_pry2oht_rr_arb;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req;
    logic       ena, lck, rdy;
    logic [7:0] oht;
    logic       vld;
    int         nvec = 0;
    int         nerr = 0;

    pry2oht_rr_arb #(.WIDTH(8), .SPLIT(2), .IMPLEMENTATION(0)) dut (
        .clk (clk),
        .rst (rst),
        .req (req),
        .ena (ena),
        .lck (lck),
        .oht (oht),
        .vld (vld),
        .rdy (rdy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        nvec++;
        assert (got === exp) else begin
            nerr++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; req = '0; ena = 1'b0; lck = 1'b0; rdy = 1'b0;
        #3;
        chk("rst_oht", oht, 8'h00);
        chk("rst_vld", {7'b0, vld}, 8'h00);
        tick();
        rst = 1'b0;

        // Round robin with wrap
        req = 8'hA4; rdy = 1'b1; ena = 1'b1;
        #1;
        chk("rr_latency_vld", {7'b0, vld}, 8'h00);
        tick(); chk("rr_g0", oht, 8'h04);
        chk("rr_g0_vld", {7'b0, vld}, 8'h01);
        tick(); chk("rr_g1", oht, 8'h20);
        tick(); chk("rr_g2", oht, 8'h80);
        tick(); chk("rr_wrap", oht, 8'h04);

        // Stall holds regardless of req
        rdy = 1'b0; req = 8'h01;
        tick(); chk("stall1", oht, 8'h04);
        tick(); chk("stall2", oht, 8'h04);
        tick(); chk("stall3", oht, 8'h04);
        chk("stall_vld", {7'b0, vld}, 8'h01);
        req = 8'h21; rdy = 1'b1;
        tick(); chk("stall_next", oht, 8'h20);

        // Lock: four beats on 0x02, then release to 0x10
        req = 8'h12;
        tick(); chk("lock_b1", oht, 8'h02);
        lck = 1'b1;
        tick(); chk("lock_b2", oht, 8'h02);
        tick(); chk("lock_b3", oht, 8'h02);
        tick(); chk("lock_b4", oht, 8'h02);
        lck = 1'b0;
        tick(); chk("lock_rel", oht, 8'h10);

        // Lock dropped by requester
        req = 8'h02;
        tick(); chk("drop_pre", oht, 8'h02);
        lck = 1'b1; req = 8'h12;
        tick(); chk("drop_lock", oht, 8'h02);
        req = 8'h10;
        tick(); chk("drop_new", oht, 8'h10);
        lck = 1'b0; req = 8'h12;
        tick(); chk("drop_unlocked", oht, 8'h02);

        // Enable gating after a fresh reset
        ena = 1'b0; req = 8'hFF;
        rst = 1'b1; #1; rst = 1'b0;
        tick(); chk("ena0_vld_a", {7'b0, vld}, 8'h00);
        tick(); chk("ena0_vld_b", {7'b0, vld}, 8'h00);
        ena = 1'b1;
        tick(); chk("ena1_grant", oht, 8'h01);
        ena = 1'b0;
        tick(); chk("ena_drop_vld", {7'b0, vld}, 8'h00);
        chk("ena_drop_oht", oht, 8'h00);
        ena = 1'b1;
        tick(); chk("ena_mask_adv", oht, 8'h02);

        // Async reset in the middle of a lock
        lck = 1'b1;
        tick(); chk("pre_rst_lock", oht, 8'h02);
        #2;
        rst = 1'b1;
        #1;
        chk("async_oht", oht, 8'h00);
        chk("async_vld", {7'b0, vld}, 8'h00);
        lck = 1'b0; req = 8'h80;
        @(negedge clk);
        rst = 1'b0;
        tick(); chk("post_rst", oht, 8'h80);
        chk("post_rst_vld", {7'b0, vld}, 8'h01);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
